mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbiter and sequencer for the processor's single-port instruction/data memory. It shares one synchronous-RAM port between the fetch stage (read-only) and the load/store stage (read/write). Each access follows a request/grant/valid handshake, issues exactly one memory command, and tracks a fixed memory read latency. It sits between the control-unit-driven pipeline stages and the memory macro.

## Interface
- ADDR_W, 8: address width.
- DATA_W, 16: data width.
- MEM_LAT, 1: cycles from the command cycle to the cycle where I_MEM_RDATA is valid; legal range 1..4.

- I_CLK  in  1  clock; all state updates on the rising edge.
- I_RESET_N  in  1  reset; asynchronous, active-low.
- I_F_REQ  in  1  fetch request; level, one access per arbitration point while high.
- I_F_ADDR  in  ADDR_W  fetch address.
- O_F_GNT  out  1  one-cycle pulse; fetch command issued this cycle.
- O_F_VALID  out  1  one-cycle pulse; O_F_RDATA updated.
- O_F_RDATA  out  DATA_W  fetch read data; held until the next fetch VALID.
- I_D_REQ, I_D_WE, I_D_ADDR[ADDR_W], I_D_WDATA[DATA_W]  in  data-port request, write enable, address, write data.
- O_D_GNT, O_D_VALID  out  1  same semantics as the fetch port; VALID also serves as the write acknowledge.
- O_D_RDATA  out  DATA_W  data read data; updated only on read completion.
- O_MEM_EN, O_MEM_WE  out  1  memory command strobe and write enable.
- O_MEM_ADDR  out  ADDR_W, O_MEM_WDATA  out  DATA_W  memory command fields.
- I_MEM_RDATA  in  DATA_W  memory read data.
- O_BUSY  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Arbitration points are the clock edges that end IDLE or RESP. Requests are ignored at all other edges.
- Arbitration at such an edge:
  - No request: go to (or stay in) IDLE.
  - One request: grant that requester.
  - Both requests: grant the requester that did not win the previous grant (round-robin).
  - The last-owner register resets to D, so the first contested grant after reset goes to F.
- At the arbitration edge, the owner, address, WE (forced 0 for F) and write data are latched.
- ISSUE (1 cycle): O_MEM_EN=1, O_MEM_WE/ADDR/WDATA driven from the latched values, owner's GNT=1. Next state is WAIT, with the latency counter loaded to MEM_LAT.
- WAIT (exactly MEM_LAT cycles): memory strobes low; counter decrements each cycle. On the edge ending the last WAIT cycle:
  - a read captures I_MEM_RDATA into the owner's RDATA register;
  - the FSM moves to RESP.
- RESP (1 cycle): owner's VALID=1. The next state is chosen by arbitration.
- A write never changes either RDATA register.
- Requesters hold ADDR/WE/WDATA stable from REQ assertion through their GNT cycle. A requester that keeps REQ high through its RESP cycle gets a new access at that arbitration point.
- Reset (asserted asynchronously, any state):
  - state to IDLE; last owner to D;
  - all GNT, VALID, MEM_* outputs, O_BUSY and both RDATA registers to 0.
  - An in-flight access is abandoned: no VALID, no further memory strobes.
- Leaving reset: the first arbitration point is the first rising edge with I_RESET_N high.

## Timing
- Request sampled at edge t: GNT and MEM_EN in cycle t+1. Read data is on I_MEM_RDATA in cycle t+1+MEM_LAT. VALID and new RDATA appear in cycle t+2+MEM_LAT.
- Back-to-back accesses, any mix of owners: one ISSUE every MEM_LAT+2 cycles (3 cycles at MEM_LAT=1).
- At most one command is outstanding. O_MEM_EN is never high in two consecutive cycles.
- GNT and VALID are never high on both ports in the same cycle.

## Test plan
- Reset: hold I_RESET_N low, drive both REQ high. Required: all outputs 0, O_BUSY=0, no MEM_EN. After release, first grant goes to F.
- Single fetch, MEM_LAT=1: F_REQ with addr 0x10 at edge 0, memory model returns 0xABCD. Required: O_F_GNT, O_MEM_EN and O_MEM_ADDR=0x10 in cycle 1; O_F_VALID=1 with O_F_RDATA=0xABCD in cycle 3; O_BUSY low from cycle 4.
- Contention: both REQ held high continuously. Required: grant order F,D,F,D with ISSUE every 3 cycles; no cycle with both GNT high.
- Write then read: D write 0x1234 to 0x20, then F read of 0x20. Required: O_MEM_WE=1 only on the D ISSUE cycle; O_D_VALID pulse; O_D_RDATA unchanged; F returns 0x1234.
- Reset mid-WAIT (MEM_LAT=3): assert I_RESET_N low in the second WAIT cycle. Required: outputs 0 immediately and no VALID afterwards; the next contested request grants F.
- Latency sweep MEM_LAT=1..4: read of 0x05 returning 0x5A5A. Required: VALID exactly MEM_LAT+1 cycles after GNT, with O_D_RDATA=0x5A5A.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter
// Shares one synchronous-RAM port between the fetch stage (read-only) and the
// load/store stage (read/write). Each access runs IDLE/RESP -> ISSUE -> WAIT
// (MEM_LAT cycles) -> RESP. Contested arbitration alternates owners
// round-robin. All outputs are registered.
module mem_port_arbiter #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 1
) (
   input  logic              I_CLK,
   input  logic              I_RESET_N,
   // fetch port (read-only)
   input  logic              I_F_REQ,
   input  logic [ADDR_W-1:0] I_F_ADDR,
   output logic              O_F_GNT,
   output logic              O_F_VALID,
   output logic [DATA_W-1:0] O_F_RDATA,
   // load/store port
   input  logic              I_D_REQ,
   input  logic              I_D_WE,
   input  logic [ADDR_W-1:0] I_D_ADDR,
   input  logic [DATA_W-1:0] I_D_WDATA,
   output logic              O_D_GNT,
   output logic              O_D_VALID,
   output logic [DATA_W-1:0] O_D_RDATA,
   // memory macro port
   output logic              O_MEM_EN,
   output logic              O_MEM_WE,
   output logic [ADDR_W-1:0] O_MEM_ADDR,
   output logic [DATA_W-1:0] O_MEM_WDATA,
   input  logic [DATA_W-1:0] I_MEM_RDATA,
   output logic              O_BUSY
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   typedef enum logic {
      OWN_F,
      OWN_D
   } owner_t;

   state_t            state;
   state_t            state_nxt;
   owner_t            owner;       // owner of the current / most recent grant
   owner_t            owner_nxt;
   logic [CNT_W-1:0]  lat_cnt;     // WAIT cycles remaining, including the current one
   logic              cur_we;      // latched write enable of the access in flight
   logic              issue_nxt;   // an ISSUE cycle starts after this edge
   logic              last_wait;   // this is the final WAIT cycle; read data is on I_MEM_RDATA
   logic [ADDR_W-1:0] sel_addr;    // command address of the requester winning this edge
   logic              sel_we;      // write enable of the winner (fetch never writes)

   assign last_wait = (state == S_WAIT) && (lat_cnt == CNT_W'(1));
   assign issue_nxt = (state_nxt == S_ISSUE);
   assign sel_addr  = (owner_nxt == OWN_F) ? I_F_ADDR : I_D_ADDR;
   assign sel_we    = (owner_nxt == OWN_D) && I_D_WE;

   // Next state and round-robin arbitration at the edges that end IDLE or RESP
   always_comb begin
      // NOTE: defaults first so every path assigns every variable; otherwise latches are inferred.
      state_nxt = state;
      owner_nxt = owner;
      case (state)
         S_IDLE, S_RESP: begin
            if (I_F_REQ && I_D_REQ) begin
               state_nxt = S_ISSUE;
               owner_nxt = (owner == OWN_D) ? OWN_F : OWN_D;
            end else if (I_F_REQ) begin
               state_nxt = S_ISSUE;
               owner_nxt = OWN_F;
            end else if (I_D_REQ) begin
               state_nxt = S_ISSUE;
               owner_nxt = OWN_D;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (last_wait) begin
               state_nxt = S_RESP;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, last-owner, latency counter and latched write enable
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         state   <= S_IDLE;
         owner   <= OWN_D;
         lat_cnt <= '0;
         cur_we  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register here samples the pre-edge values of the others.
         state <= state_nxt;
         owner <= owner_nxt;
         if (state == S_ISSUE) begin
            lat_cnt <= CNT_W'(MEM_LAT);
         end else if (state == S_WAIT) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
         end
         if (issue_nxt) begin
            cur_we <= sel_we;
         end
      end
   end

   // Registered command, grant, valid and busy outputs for the cycle after this edge
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         O_MEM_EN    <= 1'b0;
         O_MEM_WE    <= 1'b0;
         O_MEM_ADDR  <= '0;
         O_MEM_WDATA <= '0;
         O_F_GNT     <= 1'b0;
         O_D_GNT     <= 1'b0;
         O_F_VALID   <= 1'b0;
         O_D_VALID   <= 1'b0;
         O_BUSY      <= 1'b0;
      end else begin
         O_MEM_EN    <= issue_nxt;
         O_MEM_WE    <= issue_nxt && sel_we;
         O_MEM_ADDR  <= issue_nxt ? sel_addr : '0;
         O_MEM_WDATA <= (issue_nxt && sel_we) ? I_D_WDATA : '0;
         O_F_GNT     <= issue_nxt && (owner_nxt == OWN_F);
         O_D_GNT     <= issue_nxt && (owner_nxt == OWN_D);
         O_F_VALID   <= (state_nxt == S_RESP) && (owner == OWN_F);
         O_D_VALID   <= (state_nxt == S_RESP) && (owner == OWN_D);
         O_BUSY      <= (state_nxt != S_IDLE);
      end
   end

   // Read-data capture at the end of the last WAIT cycle; writes leave both registers alone
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         O_F_RDATA <= '0;
         O_D_RDATA <= '0;
      end else if (last_wait && !cur_we) begin
         if (owner == OWN_F) begin
            O_F_RDATA <= I_MEM_RDATA;
         end else begin
            O_D_RDATA <= I_MEM_RDATA;
         end
      end
   end

endmodule
